interrupt_coalescing_unit: RTL and testbench

//  Generalised interrupt controller for the Ethernet controller, with num_src_p sources.
//  Per source: enable, edge/level mode, and sticky pending with W1C clear.
//  All enabled-pending sources merge into one irq_o, which is coalesced:
//  it fires on an event-count threshold or a timeout, whichever comes first.

---
 rtl/interrupt_coalescing_unit.sv | 155 +++++++++++++++
 tb/tb_interrupt_coalescing_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_coalescing_unit.sv
// Interrupt coalescing unit: per-source enable / edge-or-level mode / sticky
// pending with W1C clear, merged into one irq_o that fires on an event-count
// threshold or a timeout, whichever comes first.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   st_idle  | nothing enabled-pending has arrived; count and timer held at 0
//   st_accum | events are being counted and the coalescing timer is running
//   st_fire  | irq_o asserted; events still counted; waiting for ack_i
module interrupt_coalescing_unit #(
  parameter int unsigned          num_src_p     = 4,
  parameter int unsigned          cnt_width_p   = 8,
  parameter int unsigned          timer_width_p = 16,
  parameter logic [num_src_p-1:0] mode_reset_p  = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [num_src_p-1:0]     src_i,
  input  logic                     en_v_i,
  input  logic [num_src_p-1:0]     en_i,
  input  logic                     mode_v_i,
  input  logic [num_src_p-1:0]     mode_i,
  input  logic                     clear_v_i,
  input  logic [num_src_p-1:0]     clear_mask_i,
  input  logic                     thresh_v_i,
  input  logic [cnt_width_p-1:0]   thresh_i,
  input  logic                     timeout_v_i,
  input  logic [timer_width_p-1:0] timeout_i,
  input  logic                     ack_i,
  output logic [num_src_p-1:0]     pending_o,
  output logic [num_src_p-1:0]     masked_pending_o,
  output logic                     irq_o,
  output logic [cnt_width_p-1:0]   event_count_o
);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_accum = 2'd1,
    st_fire  = 2'd2
  } state_e;

  state_e                   state_r, state_d;
  logic [num_src_p-1:0]     en_r, mode_r, mode_d, edge_pend_r, edge_pend_d;
  logic [num_src_p-1:0]     src_prev_r, mp_prev_r;
  logic [cnt_width_p-1:0]   thresh_r, thresh_eff, count_r, count_d, count_inc, count_acc;
  logic [timer_width_p-1:0] timeout_r, timer_r, timer_d, timer_sat;
  logic [timer_width_p:0]   timer_nx;
  logic                     irq_r, any_pend, evt, timer_hit;

  // Pending vector, enable masking and event detection
  always_comb begin
    mode_d           = mode_v_i ? mode_i : mode_r;
    // Clear first, then OR in new edges so a same-cycle rise wins; a bit whose
    // (new) mode is level is dropped, which discards it on edge->level switch.
    edge_pend_d      = ((edge_pend_r & ~({num_src_p{clear_v_i}} & clear_mask_i))
                        | (src_i & ~src_prev_r)) & mode_d;
    pending_o        = (mode_r & edge_pend_r) | (~mode_r & src_i);
    masked_pending_o = pending_o & en_r;
    any_pend         = |masked_pending_o;
    evt              = |(masked_pending_o & ~mp_prev_r);
    count_inc        = (count_r == '1) ? count_r : count_r + cnt_width_p'(1);
    count_acc        = evt ? count_inc : count_r;
    thresh_eff       = (thresh_r == '0) ? cnt_width_p'(1) : thresh_r;
    timer_nx         = {1'b0, timer_r} + (timer_width_p + 1)'(1);
    timer_sat        = (timer_r == '1) ? timer_r : timer_nx[timer_width_p-1:0];
    timer_hit        = (timeout_r != '0) && (timer_nx >= {1'b0, timeout_r});
  end

  // Next-state logic for the coalescing FSM
  always_comb begin
    state_d = state_r;
    count_d = count_r;
    timer_d = timer_r;
    case (state_r)
      st_idle: begin
        count_d = '0;
        timer_d = '0;
        if (evt) begin
          count_d = cnt_width_p'(1);
          state_d = (thresh_eff == cnt_width_p'(1)) ? st_fire : st_accum;
        end
      end
      st_accum: begin
        if (!any_pend) begin
          state_d = st_idle;
          count_d = '0;
          timer_d = '0;
        end else begin
          count_d = count_acc;
          timer_d = timer_sat;
          if ((count_acc >= thresh_eff) || timer_hit) state_d = st_fire;
        end
      end
      st_fire: begin
        if (ack_i) begin
          timer_d = '0;
          if (any_pend) begin
            state_d = st_accum;
            count_d = cnt_width_p'(1);
          end else begin
            state_d = st_idle;
            count_d = '0;
          end
        end else begin
          count_d = count_acc;
        end
      end
      default: begin
        state_d = st_idle;
        count_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // Configuration registers, sticky pending and history registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      en_r        <= '0;
      mode_r      <= mode_reset_p;
      edge_pend_r <= '0;
      src_prev_r  <= src_i;
      mp_prev_r   <= '0;
      thresh_r    <= cnt_width_p'(1);
      timeout_r   <= '0;
    end else begin
      if (en_v_i)      en_r      <= en_i;
      if (thresh_v_i)  thresh_r  <= thresh_i;
      if (timeout_v_i) timeout_r <= timeout_i;
      mode_r      <= mode_d;
      edge_pend_r <= edge_pend_d;
      src_prev_r  <= src_i;
      mp_prev_r   <= masked_pending_o;
    end
  end

  // FSM state, counters and registered irq
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= st_idle;
      count_r <= '0;
      timer_r <= '0;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_d;
      count_r <= count_d;
      timer_r <= timer_d;
      irq_r   <= (state_d == st_fire);
    end
  end

  assign irq_o         = irq_r;
  assign event_count_o = count_r;

endmodule

// File: tb/tb_interrupt_coalescing_unit.sv
// Bench for interrupt_coalescing_unit: directed steps followed by random
// stimulus, every cycle compared against a behavioural model.
module tb_interrupt_coalescing_unit;
  localparam int NS       = 4;
  localparam int PH_IDLE  = 0;
  localparam int PH_ACC   = 1;
  localparam int PH_FIRE  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  src, en, mode, clear_mask;
  logic        en_v, mode_v, clear_v, thresh_v, timeout_v, ack;
  logic [7:0]  thresh;
  logic [15:0] timeout;
  logic [3:0]  pending_o, masked_pending_o;
  logic        irq_o;
  logic [7:0]  event_count_o;

  always #5 clk = ~clk;

  interrupt_coalescing_unit #(
    .num_src_p(4), .cnt_width_p(8), .timer_width_p(16), .mode_reset_p(4'hF)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .src_i(src),
    .en_v_i(en_v), .en_i(en), .mode_v_i(mode_v), .mode_i(mode),
    .clear_v_i(clear_v), .clear_mask_i(clear_mask),
    .thresh_v_i(thresh_v), .thresh_i(thresh),
    .timeout_v_i(timeout_v), .timeout_i(timeout), .ack_i(ack),
    .pending_o(pending_o), .masked_pending_o(masked_pending_o),
    .irq_o(irq_o), .event_count_o(event_count_o)
  );

  // Behavioural model: per-source bits, phase, events counted, cycles in ACCUM
  bit m_en[NS], m_mode[NS], m_sticky[NS], m_psrc[NS], m_pmp[NS];
  int m_thresh, m_timeout, m_phase, m_count, m_age;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs(output logic [3:0] e_pend, output logic [3:0] e_mp);
    for (int i = 0; i < NS; i++) begin
      e_pend[i] = m_mode[i] ? m_sticky[i] : src[i];
      e_mp[i]   = e_pend[i] & m_en[i];
    end
  endtask

  task automatic model_advance();
    bit pend[NS];
    bit mp[NS];
    bit ev, any_mp, nm;
    int thr;
    ev = 0; any_mp = 0;
    for (int i = 0; i < NS; i++) begin
      pend[i] = m_mode[i] ? m_sticky[i] : src[i];
      mp[i]   = pend[i] && m_en[i];
      if (mp[i]) any_mp = 1;
      if (mp[i] && !m_pmp[i]) ev = 1;
    end
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) begin
        m_en[i] = 0; m_mode[i] = 1; m_sticky[i] = 0; m_psrc[i] = src[i]; m_pmp[i] = 0;
      end
      m_thresh = 1; m_timeout = 0; m_phase = PH_IDLE; m_count = 0; m_age = 0;
    end else begin
      thr = (m_thresh == 0) ? 1 : m_thresh;
      case (m_phase)
        PH_IDLE: if (ev) begin
          m_count = 1; m_age = 0;
          m_phase = (m_count >= thr) ? PH_FIRE : PH_ACC;
        end
        PH_ACC: if (!any_mp) begin
          m_phase = PH_IDLE; m_count = 0; m_age = 0;
        end else begin
          if (ev && m_count < 255) m_count++;
          m_age++;
          if (m_count >= thr || (m_timeout != 0 && m_age >= m_timeout)) m_phase = PH_FIRE;
        end
        default: if (ack) begin
          m_age = 0;
          if (any_mp) begin m_phase = PH_ACC;  m_count = 1; end
          else        begin m_phase = PH_IDLE; m_count = 0; end
        end else if (ev && m_count < 255) begin
          m_count++;
        end
      endcase
      for (int i = 0; i < NS; i++) begin
        nm = mode_v ? mode[i] : m_mode[i];
        if (clear_v && clear_mask[i]) m_sticky[i] = 0;
        if (src[i] && !m_psrc[i])     m_sticky[i] = 1;
        if (!nm)                      m_sticky[i] = 0;
        m_mode[i] = nm;
        if (en_v) m_en[i] = en[i];
        m_psrc[i] = src[i];
        m_pmp[i]  = mp[i];
      end
      if (thresh_v)  m_thresh  = int'(thresh);
      if (timeout_v) m_timeout = int'(timeout);
    end
  endtask

  // One clock cycle: check outputs against the model, advance, clear strobes
  task automatic step();
    logic [3:0] e_pend, e_mp;
    #1;
    if (chk_on) begin
      model_outputs(e_pend, e_mp);
      chk("pending", 32'(pending_o), 32'(e_pend));
      chk("masked", 32'(masked_pending_o), 32'(e_mp));
      chk("irq", 32'(irq_o), 32'(m_phase == PH_FIRE));
      chk("count", 32'(event_count_o), 32'(m_count));
    end
    model_advance();
    @(posedge clk);
    @(negedge clk);
    en_v = 0; mode_v = 0; clear_v = 0; thresh_v = 0; timeout_v = 0; ack = 0;
  endtask

  task automatic cfg_en(input logic [3:0] v);      en = v;      en_v = 1;      step(); endtask
  task automatic cfg_mode(input logic [3:0] v);    mode = v;    mode_v = 1;    step(); endtask
  task automatic cfg_thresh(input logic [7:0] v);  thresh = v;  thresh_v = 1;  step(); endtask
  task automatic cfg_timeout(input logic [15:0] v); timeout = v; timeout_v = 1; step(); endtask

  initial begin
    int n;
    logic [3:0] t;
    reset_n = 0; src = 4'b0001; en = 0; mode = 0; clear_mask = 0; thresh = 0; timeout = 0;
    en_v = 0; mode_v = 0; clear_v = 0; thresh_v = 0; timeout_v = 0; ack = 0;

    // Reset: first edge unchecked, then reset state with src[0] high
    step();
    chk_on = 1;
    step();
    chk("reset_irq", 32'(irq_o), 32'd0);
    chk("reset_count", 32'(event_count_o), 32'd0);

    // 1: source already high at release gives no edge; a later rise does
    reset_n = 1;
    step(); step(); step();
    chk("t1_no_edge", 32'(pending_o), 32'd0);
    src = 4'b0000; step();
    src = 4'b0001; step();
    chk("t1_edge_pend", 32'(pending_o[0]), 32'd1);

    // 2: level mode, thresh 1, irq one cycle after the source rises
    src = 4'b0000;
    cfg_mode(4'h0);
    cfg_en(4'hF);
    step();
    src = 4'b0100; step();
    chk("t2_irq_next", 32'(irq_o), 32'd1);
    ack = 1; step();
    chk("t2_ack_irq", 32'(irq_o), 32'd0);
    chk("t2_ack_count", 32'(event_count_o), 32'd1);
    step();
    chk("t2_refire", 32'(irq_o), 32'd1);
    src = 4'b0000; ack = 1; step();
    step();
    chk("t2_idle_count", 32'(event_count_o), 32'd0);

    // 3: edge mode, thresh 3, three separate events
    cfg_mode(4'hF);
    cfg_thresh(8'd3);
    src = 4'b0001; step(); step();
    src = 4'b0011; step(); step();
    src = 4'b0111; step();
    chk("t3_no_irq_yet", 32'(irq_o), 32'd0);
    step();
    chk("t3_irq", 32'(irq_o), 32'd1);
    chk("t3_count", 32'(event_count_o), 32'd3);
    src = 4'b0000; clear_mask = 4'hF; clear_v = 1; ack = 1; step();
    step(); step();

    // 4: thresh 8, timeout 10; ACCUM is entered two cycles after the rise
    cfg_thresh(8'd8);
    cfg_timeout(16'd10);
    src = 4'b1000; step();
    n = 1;
    while (irq_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("t4_timeout_latency", 32'(n - 2), 32'd10);
    chk("t4_count", 32'(event_count_o), 32'd1);
    src = 4'b0000; clear_mask = 4'hF; clear_v = 1; ack = 1; step();
    step();
    cfg_timeout(16'd0);

    // 5: set wins over a same-cycle clear; clear alone empties ACCUM
    src = 4'b0010; clear_mask = 4'b0010; clear_v = 1; step();
    chk("t5_set_wins", 32'(pending_o[1]), 32'd1);
    step();
    clear_mask = 4'b0010; clear_v = 1; step();
    chk("t5_cleared", 32'(pending_o[1]), 32'd0);
    step();
    chk("t5_back_idle", 32'(event_count_o), 32'd0);
    src = 4'b0000; step();

    // 6: ack together with a new event
    cfg_thresh(8'd1);
    src = 4'b0001; step(); step();
    chk("t6_fire", 32'(irq_o), 32'd1);
    src = 4'b0101; step();
    ack = 1; step();
    chk("t6_ack_irq", 32'(irq_o), 32'd0);
    chk("t6_ack_count", 32'(event_count_o), 32'd1);
    step();
    chk("t6_refire", 32'(irq_o), 32'd1);
    src = 4'b0000; clear_mask = 4'hF; clear_v = 1; ack = 1; step();
    step(); step();

    // Random traffic, including occasional mid-operation resets
    for (int k = 0; k < 3000; k++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      t = 4'b0000;
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 5) == 0) t[i] = 1'b1;
      src        = src ^ t;
      en_v       = ($urandom_range(0, 15) == 0);
      en         = 4'($urandom);
      mode_v     = ($urandom_range(0, 19) == 0);
      mode       = 4'($urandom);
      clear_v    = ($urandom_range(0, 5) == 0);
      clear_mask = 4'($urandom);
      thresh_v   = ($urandom_range(0, 19) == 0);
      thresh     = 8'($urandom_range(0, 5));
      timeout_v  = ($urandom_range(0, 19) == 0);
      timeout    = 16'($urandom_range(0, 12));
      ack        = ($urandom_range(0, 3) == 0);
      step();
    end
    reset_n = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
